onewire_slave_phy: RTL

Device-side (responder) 1-Wire physical layer, the counterpart of the master reset/presence and slot generator. It watches the open-drain bus, detects master reset pulses and answers with a presence pulse. It then decodes master write slots into bits and answers master read slots by driving the bus from a supplied bit. It sits between the bus pad (`bus_in` sense, `drive_low` pull-down enable) and a byte-level device engine.

---
 rtl/onewire_slave_phy.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/onewire_slave_phy.sv
// rtl/onewire_slave_phy.sv - 1-Wire device-side PHY: reset/presence responder and slot decoder
module onewire_slave_phy #(
    parameter int CLKS_PER_US  = 27,
    parameter int RESET_MIN_US = 480,
    parameter int PRES_WAIT_US = 30,
    parameter int PRES_LEN_US  = 120,
    parameter int SAMPLE_US    = 30,
    parameter int READ_HOLD_US = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic bus_in,
    output logic drive_low,
    output logic reset_seen,
    output logic rx_valid,
    output logic rx_bit,
    input  logic tx_en,
    input  logic tx_bit,
    output logic tx_taken
);

    localparam int T_RESET_MIN = RESET_MIN_US * CLKS_PER_US;
    localparam int CW          = $clog2(T_RESET_MIN) + 1;

    // Outputs are registered, so each "at T" decision is taken at cnt == T-1
    // and becomes visible in the cycle where cnt == T.
    localparam logic [CW-1:0] SAMPLE_AT = CW'(SAMPLE_US * CLKS_PER_US - 1);
    localparam logic [CW-1:0] HOLD_AT   = CW'(READ_HOLD_US * CLKS_PER_US - 1);
    localparam logic [CW-1:0] PWAIT_AT  = CW'(PRES_WAIT_US * CLKS_PER_US - 1);
    localparam logic [CW-1:0] PLEN_AT   = CW'(PRES_LEN_US * CLKS_PER_US - 1);
    // In SLOT_END bus_s has been low for cnt+2 cycles (edge-detect cycle included).
    localparam logic [CW-1:0] RESET_AT  = CW'(T_RESET_MIN - 2);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        SLOT,
        SLOT_END,
        RST_HIGH,
        PRES_WAIT,
        PRES_DRIVE,
        PRES_RECOVER
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sync1;
    logic          bus_s;
    logic          bus_q;
    logic          read_slot;
    logic          fall;

    assign fall = bus_q & ~bus_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sync1      <= 1'b1;
            bus_s      <= 1'b1;
            bus_q      <= 1'b1;
            read_slot  <= 1'b0;
            drive_low  <= 1'b0;
            reset_seen <= 1'b0;
            rx_valid   <= 1'b0;
            rx_bit     <= 1'b0;
            tx_taken   <= 1'b0;
        end else begin
            sync1      <= bus_in;
            bus_s      <= sync1;
            bus_q      <= bus_s;
            reset_seen <= 1'b0;
            rx_valid   <= 1'b0;
            tx_taken   <= 1'b0;
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state     <= SLOT;
                        cnt       <= '0;
                        read_slot <= tx_en;
                        tx_taken  <= tx_en;
                        drive_low <= tx_en & ~tx_bit;
                    end
                end
                SLOT: begin
                    if (read_slot && cnt == HOLD_AT) begin
                        drive_low <= 1'b0;
                    end
                    if (cnt == SAMPLE_AT) begin
                        if (!read_slot) begin
                            rx_bit   <= bus_s;
                            rx_valid <= 1'b1;
                        end
                        state <= SLOT_END;
                    end
                end
                SLOT_END: begin
                    // Read hold may outlast the sample point when configured longer.
                    if (read_slot && cnt == HOLD_AT) begin
                        drive_low <= 1'b0;
                    end
                    if (bus_s) begin
                        state <= IDLE;
                    end else if (cnt == RESET_AT && !drive_low) begin
                        reset_seen <= 1'b1;
                        state      <= RST_HIGH;
                    end
                end
                RST_HIGH: begin
                    if (bus_s) begin
                        state <= PRES_WAIT;
                        cnt   <= '0;
                    end
                end
                PRES_WAIT: begin
                    if (cnt == PWAIT_AT) begin
                        drive_low <= 1'b1;
                        state     <= PRES_DRIVE;
                        cnt       <= '0;
                    end
                end
                PRES_DRIVE: begin
                    if (cnt == PLEN_AT) begin
                        drive_low <= 1'b0;
                        state     <= PRES_RECOVER;
                    end
                end
                PRES_RECOVER: begin
                    if (bus_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    drive_low <= 1'b0;
                end
            endcase
        end
    end

endmodule
